if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the five-stage pipeline. Owns the program counter, issues requests to a variable-latency instruction memory, and presents the fetched instruction plus PC+4 to the IF/ID pipeline register. Honours the hazard unit's stall (`keep`) and redirects from branch/jump resolution. Inserts NOP bubbles while memory is busy.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP`, default 32'h0000_0000: instruction word driven when no valid instruction is available.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `keep`  in  1  stall from the hazard unit; the IF/ID register is also holding.
- `redirect`  in  1  taken branch or jump; load `redirect_pc`.
- `redirect_pc`  in  32  target; bits [1:0] ignored and forced to 00.
- `imem_req`  out  1  memory request valid.
- `imem_addr`  out  32  request address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1  completes the current request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `fetch_instruction`  out  32  to IF/ID.
- `IF_PCjia4`  out  32  PC+4 of `fetch_instruction`; 0 when not valid.
- `fetch_valid`  out  1  `fetch_instruction` is a real instruction.
- `pc`  out  32  current PC register, for debug.

## Operation
- Registers: `pc`, `stale_addr`, `ibuf` (32 bits each), and `state` ∈ {FETCH, HOLD, DRAIN}.
- Reset: `pc`←RESET_PC, `state`←FETCH, `ibuf`←NOP, `stale_addr`←0. While `reset`=1, the outputs are forced to `imem_req`=0, `fetch_valid`=0, `fetch_instruction`=NOP, `IF_PCjia4`=0. `imem_addr` is driven from `pc`.
- Priority at each edge: reset > redirect > keep > normal.
- FETCH:
  - Outputs: `imem_req`=1, `imem_addr`=`pc`.
  - `fetch_valid`=`imem_ready` & !`redirect`.
  - When valid: `fetch_instruction`=`imem_rdata` and `IF_PCjia4`=`pc`+4. Otherwise NOP and 0.
  - `redirect` & !`imem_ready`: `stale_addr`←`pc`, `pc`←target, go to DRAIN.
  - `redirect` & `imem_ready`: data discarded, `pc`←target, stay in FETCH.
  - `imem_ready` & `keep`: `ibuf`←`imem_rdata`, go to HOLD, `pc` unchanged.
  - `imem_ready` & !`keep`: `pc`←`pc`+4, stay in FETCH.
  - !`imem_ready`: hold and emit a bubble. `keep` does not matter.
- HOLD:
  - Outputs: `imem_req`=0, `fetch_valid`=!`redirect`, `fetch_instruction`=`ibuf`, `IF_PCjia4`=`pc`+4.
  - `redirect`: `pc`←target, go to FETCH.
  - !`keep`: `pc`←`pc`+4, go to FETCH.
  - Otherwise stay in HOLD.
- DRAIN (abandoned request still in flight):
  - Outputs: `imem_req`=1, `imem_addr`=`stale_addr`, `fetch_valid`=0, NOP.
  - `redirect`: `pc`←new target, stay in DRAIN.
  - `imem_ready`: data discarded, go to FETCH.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. `pc`[1:0] is always 00.
- The block never re-issues an address twice for one instruction, except after a redirect to the same address.

## Timing
- Zero-wait memory (`imem_ready`=1 every cycle): one instruction per cycle. The instruction at address A appears on `fetch_instruction` in the same cycle `pc`=A.
- N-cycle memory latency: N-1 bubble cycles, then a valid cycle.
- Redirect asserted in cycle t (FETCH, ready): earliest valid target instruction is in cycle t+1.
- Redirect asserted in cycle t (FETCH, not ready): DRAIN lasts until the stale request completes. The target request starts the cycle after that completion.
- `fetch_valid` is 0 in the cycle `redirect` is high. The control unit flushes IF/ID in that cycle.
- `keep` never affects `imem_req` in FETCH or DRAIN. An outstanding request always completes.
- Reset mid-DRAIN or mid-HOLD: pending data is discarded. Instruction memory shares `reset`.

## Test plan
- Reset, then zero-wait memory returning `{addr}` as data for 4 cycles → `fetch_instruction` = 0,4,8,12; `IF_PCjia4` = 4,8,12,16; `fetch_valid`=1 each cycle.
- 2-cycle latency (`imem_ready` every other cycle) → alternating bubble (NOP, `fetch_valid`=0) and valid; `imem_addr` steady during each wait.
- `keep`=1 for 3 cycles on the cycle data for 0x8 arrives → HOLD; `fetch_instruction`=data(0x8) for 3 cycles; `imem_req`=0; then `pc`=0xC, FETCH.
- `redirect`=1, `redirect_pc`=0x103 while a request to 0x10 is pending → `imem_addr` stays 0x10 until ready, data discarded, next request 0x100.
- Simultaneous `redirect` and `keep` in HOLD → redirect wins: `pc`=target, `fetch_valid`=0 that cycle.
- `pc`=0xFFFF_FFFC, ready, no stall → `IF_PCjia4`=0, next `pc`=0. Reset asserted mid-DRAIN → `pc`=RESET_PC, state FETCH.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory and feeds the IF/ID register, with stall, redirect and bubble handling.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        keep,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] fetch_instruction,
   output logic [31:0] IF_PCjia4,
   output logic        fetch_valid,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] stale_addr_reg, stale_addr_next;
   logic [31:0] ibuf_reg, ibuf_next;

   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        unused_low_bits;

   // Targets are word aligned; the low two bits of the request are dropped.
   assign target          = {redirect_pc[31:2], 2'b00};
   assign unused_low_bits = ^redirect_pc[1:0];
   assign pc_plus4        = pc_reg + 32'd4;
   assign pc              = pc_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= FETCH;
         pc_reg         <= RESET_PC;
         stale_addr_reg <= 32'h0000_0000;
         ibuf_reg       <= NOP;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         stale_addr_reg <= stale_addr_next;
         ibuf_reg       <= ibuf_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      stale_addr_next   = stale_addr_reg;
      ibuf_next         = ibuf_reg;
      imem_req          = 1'b0;
      imem_addr         = pc_reg;
      fetch_valid       = 1'b0;
      fetch_instruction = NOP;
      IF_PCjia4         = 32'h0000_0000;

      case (state_reg)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready && !redirect) begin
               fetch_valid       = 1'b1;
               fetch_instruction = imem_rdata;
               IF_PCjia4         = pc_plus4;
            end
            if (redirect) begin
               pc_next = target;
               // The request in flight cannot be cancelled; remember it and drain.
               if (!imem_ready) begin
                  stale_addr_next = pc_reg;
                  state_next      = DRAIN;
               end
            end else if (imem_ready) begin
               if (keep) begin
                  ibuf_next  = imem_rdata;
                  state_next = HOLD;
               end else begin
                  pc_next = pc_plus4;
               end
            end
         end

         HOLD: begin
            if (!redirect) begin
               fetch_valid       = 1'b1;
               fetch_instruction = ibuf_reg;
               IF_PCjia4         = pc_plus4;
            end
            if (redirect) begin
               pc_next    = target;
               state_next = FETCH;
            end else if (!keep) begin
               pc_next    = pc_plus4;
               state_next = FETCH;
            end
         end

         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = stale_addr_reg;
            if (redirect) begin
               pc_next = target;
            end
            // Once the stale request completes it must not be issued again.
            if (imem_ready) begin
               state_next = FETCH;
            end
         end

         default: begin
            state_next = FETCH;
         end
      endcase

      if (reset) begin
         imem_req          = 1'b0;
         imem_addr         = pc_reg;
         fetch_valid       = 1'b0;
         fetch_instruction = NOP;
         IF_PCjia4         = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run
// against a behavioural model of the fetch rules.
`timescale 1ns/1ps
module tb_if_fetch;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_W   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        keep;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] fetch_instruction;
   logic [31:0] IF_PCjia4;
   logic        fetch_valid;
   logic [31:0] pc;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] salt = 32'h0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
      .clk(clk), .reset(reset), .keep(keep), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .fetch_instruction(fetch_instruction), .IF_PCjia4(IF_PCjia4),
      .fetch_valid(fetch_valid), .pc(pc)
   );

   // Applies one cycle of inputs at the falling edge; memory returns addr^salt.
   task automatic drive(input logic r, input logic k, input logic rd,
                        input logic [31:0] rp, input logic rdy);
      @(negedge clk);
      reset       = r;
      keep        = k;
      redirect    = rd;
      redirect_pc = rp;
      imem_ready  = rdy;
      imem_rdata  = imem_addr ^ salt;
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 32'h0, 1);
      drive(1, 1, 0, 32'h0, 1);
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", fetch_valid); end
      n_checks++; if (fetch_instruction !== NOP_W) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", fetch_instruction, NOP_W); end
      n_checks++; if (IF_PCjia4 !== 32'h0) begin n_fail++; $display("FAIL rst_pcj got=%h exp=0", IF_PCjia4); end
      n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", pc, RST_PC); end
      n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RST_PC); end
   endtask

   task automatic test_zero_wait();
      drive(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 32'h0, 1);
         n_checks++; if (fetch_instruction !== 32'(4*i)) begin n_fail++; $display("FAIL zw_instr i=%0d got=%h exp=%h", i, fetch_instruction, 32'(4*i)); end
         n_checks++; if (IF_PCjia4 !== 32'(4*i+4)) begin n_fail++; $display("FAIL zw_pcj i=%0d got=%h exp=%h", i, IF_PCjia4, 32'(4*i+4)); end
         n_checks++; if (fetch_valid !== 1'b1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_valid i=%0d got=%b/%b exp=1/1", i, fetch_valid, imem_req); end
      end
   endtask

   task automatic test_latency2();
      drive(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 32'h0, 0);
         n_checks++; if (fetch_valid !== 1'b0 || fetch_instruction !== NOP_W) begin n_fail++; $display("FAIL lat_bubble i=%0d got=%b/%h exp=0/%h", i, fetch_valid, fetch_instruction, NOP_W); end
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i)) begin n_fail++; $display("FAIL lat_addr_wait i=%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4*i)); end
         drive(0, 0, 0, 32'h0, 1);
         n_checks++; if (imem_addr !== 32'(4*i)) begin n_fail++; $display("FAIL lat_addr_ready i=%0d got=%h exp=%h", i, imem_addr, 32'(4*i)); end
         n_checks++; if (fetch_valid !== 1'b1 || fetch_instruction !== 32'(4*i)) begin n_fail++; $display("FAIL lat_valid i=%0d got=%b/%h exp=1/%h", i, fetch_valid, fetch_instruction, 32'(4*i)); end
      end
   endtask

   task automatic test_keep();
      drive(1, 0, 0, 32'h0, 0);
      drive(0, 0, 0, 32'h0, 1);
      drive(0, 0, 0, 32'h0, 1);
      drive(0, 1, 0, 32'h0, 1);
      n_checks++; if (fetch_instruction !== 32'h8 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL keep_arrive got=%b/%h exp=1/00000008", fetch_valid, fetch_instruction); end
      for (int i = 0; i < 3; i++) begin
         drive(0, (i < 2) ? 1'b1 : 1'b0, 0, 32'h0, 1'($urandom_range(0, 1)));
         n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL keep_req i=%0d got=%b exp=0", i, imem_req); end
         n_checks++; if (fetch_instruction !== 32'h8 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL keep_hold i=%0d got=%b/%h exp=1/00000008", i, fetch_valid, fetch_instruction); end
         n_checks++; if (IF_PCjia4 !== 32'hC || pc !== 32'h8) begin n_fail++; $display("FAIL keep_pc i=%0d got=%h/%h exp=0000000c/00000008", i, IF_PCjia4, pc); end
      end
      drive(0, 0, 0, 32'h0, 1);
      n_checks++; if (pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL keep_resume got=%h/%b/%h exp=0000000c/1/0000000c", pc, imem_req, imem_addr); end
      n_checks++; if (fetch_instruction !== 32'hC) begin n_fail++; $display("FAIL keep_next got=%h exp=0000000c", fetch_instruction); end
   endtask

   task automatic test_redirect_pending();
      drive(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 32'h0, 1);
      drive(0, 0, 1, 32'h103, 0);
      n_checks++; if (imem_addr !== 32'h10 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_issue got=%h/%b exp=00000010/0", imem_addr, fetch_valid); end
      drive(0, 1, 0, 32'h0, 0);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL rdp_drain_addr got=%b/%h exp=1/00000010", imem_req, imem_addr); end
      n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL rdp_pc got=%h exp=00000100", pc); end
      drive(0, 0, 0, 32'h0, 1);
      n_checks++; if (imem_addr !== 32'h10 || fetch_valid !== 1'b0 || fetch_instruction !== NOP_W) begin n_fail++; $display("FAIL rdp_discard got=%h/%b/%h exp=00000010/0/%h", imem_addr, fetch_valid, fetch_instruction, NOP_W); end
      drive(0, 0, 0, 32'h0, 1);
      n_checks++; if (imem_addr !== 32'h100 || fetch_instruction !== 32'h100 || IF_PCjia4 !== 32'h104) begin n_fail++; $display("FAIL rdp_target got=%h/%h/%h exp=00000100/00000100/00000104", imem_addr, fetch_instruction, IF_PCjia4); end
   endtask

   task automatic test_redirect_in_hold();
      drive(1, 0, 0, 32'h0, 0);
      drive(0, 1, 0, 32'h0, 1);
      drive(0, 1, 1, 32'h40, 0);
      n_checks++; if (fetch_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rdh_flush got=%b/%b exp=0/0", fetch_valid, imem_req); end
      drive(0, 0, 0, 32'h0, 1);
      n_checks++; if (pc !== 32'h40 || fetch_instruction !== 32'h40 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rdh_target got=%h/%h/%b exp=00000040/00000040/1", pc, fetch_instruction, fetch_valid); end
   endtask

   task automatic test_wrap();
      drive(1, 0, 0, 32'h0, 0);
      drive(0, 0, 1, 32'hFFFF_FFFE, 1);
      n_checks++; if (fetch_valid !== 1'b0 || IF_PCjia4 !== 32'h0) begin n_fail++; $display("FAIL wrap_redir got=%b/%h exp=0/00000000", fetch_valid, IF_PCjia4); end
      drive(0, 0, 0, 32'h0, 1);
      n_checks++; if (pc !== 32'hFFFF_FFFC || fetch_instruction !== 32'hFFFF_FFFC || IF_PCjia4 !== 32'h0) begin n_fail++; $display("FAIL wrap_top got=%h/%h/%h exp=fffffffc/fffffffc/00000000", pc, fetch_instruction, IF_PCjia4); end
      drive(0, 0, 0, 32'h0, 1);
      n_checks++; if (pc !== 32'h0 || IF_PCjia4 !== 32'h4) begin n_fail++; $display("FAIL wrap_next got=%h/%h exp=00000000/00000004", pc, IF_PCjia4); end
   endtask

   task automatic test_reset_in_drain();
      drive(1, 0, 0, 32'h0, 0);
      drive(0, 0, 0, 32'h0, 1);
      drive(0, 0, 1, 32'h200, 0);
      drive(0, 0, 0, 32'h0, 0);
      n_checks++; if (imem_addr !== 32'h4 || pc !== 32'h200) begin n_fail++; $display("FAIL rsd_drain got=%h/%h exp=00000004/00000200", imem_addr, pc); end
      drive(1, 0, 0, 32'h0, 0);
      n_checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rsd_reset got=%b/%b exp=0/0", imem_req, fetch_valid); end
      drive(0, 0, 0, 32'h0, 1);
      n_checks++; if (pc !== RST_PC || imem_addr !== RST_PC || imem_req !== 1'b1 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rsd_after got=%h/%h/%b/%b exp=%h/%h/1/1", pc, imem_addr, imem_req, fetch_valid, RST_PC, RST_PC); end
   endtask

   // Random traffic against a model of the fetch rules. The model remembers
   // whether an instruction is parked for the stalled IF/ID register and
   // whether an abandoned request is still owed a completion.
   task automatic test_random();
      logic [31:0] m_pc, m_word, m_stale, e_addr, e_data, e_instr, e_pcj;
      logic        m_parked, m_owed, e_req, e_valid;
      logic        r, k, rd, rdy;
      logic [31:0] rp;
      salt = 32'h5A5A_1234;
      drive(1, 0, 0, 32'h0, 0);
      m_pc = RST_PC; m_parked = 0; m_owed = 0; m_word = NOP_W; m_stale = 0;
      for (int c = 0; c < 3000; c++) begin
         r   = ($urandom_range(0, 99) == 0);
         k   = ($urandom_range(0, 2) == 0);
         rd  = ($urandom_range(0, 7) == 0);
         rp  = $urandom;
         rdy = ($urandom_range(0, 2) != 0);
         if (m_owed && rd) rdy = 1'b0;
         drive(r, k, rd, rp, rdy);

         e_addr = m_owed ? m_stale : m_pc;
         e_data = e_addr ^ salt;
         if (r) begin
            e_req = 0; e_valid = 0; e_addr = m_pc;
         end else if (m_owed) begin
            e_req = 1; e_valid = 0;
         end else if (m_parked) begin
            e_req = 0; e_valid = !rd;
         end else begin
            e_req = 1; e_valid = rdy && !rd;
         end
         e_instr = !e_valid ? NOP_W : (m_parked ? m_word : e_data);
         e_pcj   = e_valid ? m_pc + 32'd4 : 32'h0;

         n_checks++; if (imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
         if (e_req || r) begin
            n_checks++; if (imem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, e_addr); end
         end
         n_checks++; if (fetch_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, fetch_valid, e_valid); end
         n_checks++; if (fetch_instruction !== e_instr) begin n_fail++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, fetch_instruction, e_instr); end
         n_checks++; if (IF_PCjia4 !== e_pcj) begin n_fail++; $display("FAIL rnd_pcj c=%0d got=%h exp=%h", c, IF_PCjia4, e_pcj); end
         n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, pc, m_pc); end

         if (r) begin
            m_pc = RST_PC; m_parked = 0; m_owed = 0; m_word = NOP_W; m_stale = 0;
         end else if (m_owed) begin
            if (rd) m_pc = rp & 32'hFFFF_FFFC;
            else if (rdy) m_owed = 0;
         end else if (m_parked) begin
            if (rd) begin m_pc = rp & 32'hFFFF_FFFC; m_parked = 0; end
            else if (!k) begin m_pc = m_pc + 32'd4; m_parked = 0; end
         end else if (rd) begin
            if (!rdy) begin m_stale = m_pc; m_owed = 1; end
            m_pc = rp & 32'hFFFF_FFFC;
         end else if (rdy) begin
            if (k) begin m_word = e_data; m_parked = 1; end
            else m_pc = m_pc + 32'd4;
         end
      end
      salt = 32'h0;
   endtask

   initial begin
      reset = 1; keep = 0; redirect = 0; redirect_pc = 0; imem_ready = 0; imem_rdata = 0;
      test_reset();
      test_zero_wait();
      test_latency2();
      test_keep();
      test_redirect_pending();
      test_redirect_in_hold();
      test_wrap();
      test_reset_in_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
